// File: rtl/serial_subtractor_pkg.sv
// Shared types and step-count helpers for the digit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit steps_legal(input int width, input int digit);
    return (width >= 1) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

  // Falls back to 1 on illegal input so elaboration reaches the explicit error.
  function automatic int calc_steps(input int width, input int digit);
    return steps_legal(width, digit) ? (width / digit) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// Combinational DIGIT-wide ripple subtractor built from full-subtract bits.
module sub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] w_br;

  assign w_br[0] = bin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign d[i]      = a[i] ^ b[i] ^ w_br[i];
    assign w_br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_br[i]);
  end

  assign bout = w_br[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor, DIGIT bits per clock with a registered borrow.
// Optional signed-overflow output enabled by SERIAL_SUBTRACTOR_SIGNED_OVF_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow_out
);

  localparam int STEPS = calc_steps(WIDTH, DIGIT);
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (!steps_legal(WIDTH, DIGIT)) begin : g_illegal
    $error("serial_subtractor: DIGIT must be >= 1 and divide WIDTH");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_diff;
  logic             r_bin;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [DIGIT-1:0] w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_acc_nxt;

  sub_digit #(.DIGIT(DIGIT)) u_sub (
    .a    (r_x[DIGIT-1:0]),
    .b    (r_y[DIGIT-1:0]),
    .bin  (r_bin),
    .d    (w_d),
    .bout (w_bout)
  );

  // New digits enter at the MSB so the last step leaves the LSB digit at the bottom.
  if (WIDTH == DIGIT) begin : g_single
    assign w_acc_nxt = w_d;
  end else begin : g_multi
    assign w_acc_nxt = {w_d, r_acc[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_cnt == CW'(STEPS - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_diff   <= '0;
      r_bin    <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_load) begin
      r_x   <= x;
      r_y   <= y;
      r_bin <= 1'b0;
      r_cnt <= '0;
    end else if (w_step) begin
      r_x   <= r_x >> DIGIT;
      r_y   <= r_y >> DIGIT;
      r_bin <= w_bout;
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_diff   <= w_acc_nxt;
        r_borrow <= w_bout;
      end
    end
  end

`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
  logic r_xs;
  logic r_ys;
  logic r_ovf;

  // Operand sign bits are shifted out during RUN, so keep them from the load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xs  <= 1'b0;
      r_ys  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_load) begin
      r_xs <= x[WIDTH-1];
      r_ys <= y[WIDTH-1];
    end else if (w_last) begin
      r_ovf <= (r_xs != r_ys) && (w_acc_nxt[WIDTH-1] != r_xs);
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy       = (r_state == RUN);
  assign done       = (r_state == DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow;

endmodule
